// File: rtl/fsk_pkg.sv
// Shared FSK constants and state type; the downstream decoder uses the same
// SYMBOL_CYCLES window so encoder and decoder stay symbol-aligned.
package fsk_pkg;

    localparam int unsigned SYMBOL_CYCLES    = 33;
    localparam int unsigned HALF_PERIOD_ONE  = 1;
    localparam int unsigned HALF_PERIOD_ZERO = 4;
    localparam int unsigned FIFO_DEPTH       = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsk_bit_fifo.sv
// Small circular bit buffer feeding the FSK encoder: valid/ready push,
// pop strobe, and count/empty/full status from the registered occupancy.
module fsk_bit_fifo #(
    parameter int unsigned DEPTH = fsk_pkg::FIFO_DEPTH
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       push_valid,
    input  logic                                       push_bit,
    output logic                                       push_ready,
    input  logic                                       pop,
    output logic                                       head,
    output logic [fsk_pkg::width_of(DEPTH + 1) - 1:0]  count,
    output logic                                       empty,
    output logic                                       full
);
    import fsk_pkg::*;

    localparam int unsigned PW = width_of(DEPTH);
    localparam int unsigned CW = width_of(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Status comes only from the registered count, so a same-cycle pop
    // never raises push_ready.
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_bit;
        end
    end

endmodule

// File: rtl/fsk_encoder.sv
// Buffered FSK modulator: each bit becomes a SYMBOL_CYCLES-long square-wave
// symbol. Define FSK_ENCODER_IDLE_TONE_EN for a continuous "0" tone while idle.
module fsk_encoder #(
    parameter int unsigned SYMBOL_CYCLES    = fsk_pkg::SYMBOL_CYCLES,
    parameter int unsigned HALF_PERIOD_ONE  = fsk_pkg::HALF_PERIOD_ONE,
    parameter int unsigned HALF_PERIOD_ZERO = fsk_pkg::HALF_PERIOD_ZERO,
    parameter int unsigned FIFO_DEPTH       = fsk_pkg::FIFO_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic out_wave,
    output logic sym_start,
    output logic busy
);
    import fsk_pkg::*;

    localparam int unsigned HALF_MAX = (HALF_PERIOD_ONE > HALF_PERIOD_ZERO) ?
                                       HALF_PERIOD_ONE : HALF_PERIOD_ZERO;
    localparam int unsigned SW = width_of(SYMBOL_CYCLES);
    localparam int unsigned HW = width_of(HALF_MAX);
    localparam int unsigned CW = width_of(FIFO_DEPTH + 1);

    localparam logic [SW-1:0] SYM_LAST       = SW'(SYMBOL_CYCLES - 1);
    localparam logic [HW-1:0] HALF_LAST_ONE  = HW'(HALF_PERIOD_ONE - 1);
    localparam logic [HW-1:0] HALF_LAST_ZERO = HW'(HALF_PERIOD_ZERO - 1);

    fsk_state_t    state;
    logic [SW-1:0] sym_cnt;
    logic [HW-1:0] half_cnt;
    logic          cur_bit;

    logic          fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          sym_last;
    logic          half_last;
    logic          unused_fifo_status;

    fsk_bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (in_valid),
        .push_bit   (in_bit),
        .push_ready (in_ready),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Occupancy detail is not needed here; ready and empty carry it.
    assign unused_fifo_status = ^{fifo_count, fifo_full};

    assign sym_last  = (state == SEND) && (sym_cnt == SYM_LAST);
    assign half_last = cur_bit ? (half_cnt == HALF_LAST_ONE)
                               : (half_cnt == HALF_LAST_ZERO);
    // Fetch a new bit when idle, or on the final symbol cycle for a gapless handoff.
    assign pop = !fifo_empty && ((state == IDLE) || sym_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            sym_cnt   <= '0;
            half_cnt  <= '0;
            cur_bit   <= 1'b0;
            out_wave  <= 1'b0;
            sym_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sym_start <= 1'b0;
            if (pop) begin
                state     <= SEND;
                cur_bit   <= fifo_head;
                sym_cnt   <= '0;
                half_cnt  <= '0;
                out_wave  <= 1'b0;
                sym_start <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    SEND: begin
                        if (sym_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            sym_cnt  <= '0;
                            half_cnt <= '0;
                            out_wave <= 1'b0;
                        end else begin
                            sym_cnt <= sym_cnt + SW'(1);
                            if (half_last) begin
                                half_cnt <= '0;
                                out_wave <= ~out_wave;
                            end else begin
                                half_cnt <= half_cnt + HW'(1);
                            end
                        end
                    end
                    IDLE: begin
`ifdef FSK_ENCODER_IDLE_TONE_EN
                        if (half_cnt == HALF_LAST_ZERO) begin
                            half_cnt <= '0;
                            out_wave <= ~out_wave;
                        end else begin
                            half_cnt <= half_cnt + HW'(1);
                        end
`else
                        half_cnt <= '0;
                        out_wave <= 1'b0;
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
